priority_eval_seq: RTL

Parametrised per-pixel layer priority evaluator and palette fetcher for the GBA graphics pipeline. It sits between the BG/OBJ renderers and the colour-effects (blend) stage. For each accepted pixel it sequentially ranks `NUM_BG` background entries plus one OBJ entry under the window mask. It keeps the top two visible layers, then fetches their 15-bit colours from PRAM over a request/grant/return handshake with arbitrary latency.

---
 rtl/pe_pkg.sv | 33 +++
 rtl/pe_rank.sv | 25 ++
 rtl/priority_eval_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types for the layer priority evaluator: layer entry, FSM states and
// PRAM address construction.
package pe_pkg;

  localparam int LAYER_PAL_W  = 8;
  localparam int LAYER_ADDR_W = LAYER_PAL_W + 2;
  localparam int OBJ_PAL_BASE = LAYER_PAL_W + 1;
  localparam logic [LAYER_ADDR_W-1:0] BACKDROP_ADDR = '0;

  typedef struct packed {
    logic                   valid;
    logic [1:0]             prio;
    logic                   is_obj;
    logic [2:0]             bg_no;
    logic [LAYER_PAL_W-1:0] pal;
  } layer_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SCAN, ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1, ST_OUT
  } state_t;

  // OBJ palette sits in the upper half of PRAM; halfword entries, hence bit 0 = 0.
  function automatic logic [LAYER_ADDR_W-1:0] layer_addr(input layer_t l);
    logic [LAYER_ADDR_W-1:0] a;
    a = BACKDROP_ADDR;
    if (l.valid) begin
      a[OBJ_PAL_BASE]     = l.is_obj;
      a[LAYER_PAL_W:1]    = l.pal;
    end
    return a;
  endfunction

endpackage

// File: rtl/pe_rank.sv
// Combinational ranking: does a candidate entry displace the incumbent layer?
module pe_rank
  import pe_pkg::*;
(
  input  layer_t cand,
  input  logic   cand_en,
  input  layer_t incumbent,
  output logic   wins
);

  function automatic logic visible(input layer_t l, input logic en);
    return l.valid && en && (l.pal != '0);
  endfunction

  // Lower prio wins; on a tie OBJ beats BG, then lower BG number wins.
  function automatic logic beats(input layer_t a, input layer_t b);
    if (!visible(b, 1'b1)) return 1'b1;
    if (a.prio != b.prio) return a.prio < b.prio;
    if (a.is_obj != b.is_obj) return a.is_obj;
    return a.bg_no < b.bg_no;
  endfunction

  assign wins = visible(cand, cand_en) && beats(cand, incumbent);

endmodule

// File: rtl/priority_eval_seq.sv
// Per-pixel layer priority evaluator: sequentially ranks OBJ + BG entries,
// keeps the top two visible layers and fetches their colours from PRAM.
module priority_eval_seq
  import pe_pkg::*;
#(
  parameter int NUM_BG  = 4,
  parameter int PAL_W   = LAYER_PAL_W,
  parameter int PRAM_AW = PAL_W + 2
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  layer_t [NUM_BG-1:0]   in_bg,
  input  layer_t                in_obj,
  input  logic   [NUM_BG:0]     in_mask,
  input  logic                  in_effects,
  output logic                  pram_req,
  output logic   [PRAM_AW-1:0]  pram_addr,
  input  logic                  pram_gnt,
  input  logic                  pram_rvalid,
  input  logic   [15:0]         pram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output layer_t                out_layer0,
  output layer_t                out_layer1,
  output logic   [14:0]         out_color0,
  output logic   [14:0]         out_color1,
  output logic                  out_effects
);

  state_t                  state, state_nx;
  logic   [3:0]            cnt;
  layer_t [NUM_BG-1:0]     bg_q;
  layer_t                  obj_q;
  logic   [NUM_BG:0]       mask_q;
  logic                    eff_q;
  layer_t                  top_q, sec_q;
  logic   [14:0]           color0_q, color1_q;

  layer_t                  cand;
  logic                    cand_en;
  logic                    win_top, win_sec;
  logic [LAYER_ADDR_W-1:0] addr0, addr1;
  logic                    unused_rdata_msb;

  assign unused_rdata_msb = pram_rdata[15];
  assign addr0 = layer_addr(top_q);
  assign addr1 = layer_addr(sec_q);

  // Scan order: cnt 0 = OBJ, cnt i = BG(i-1)
  always_comb begin
    cand    = obj_q;
    cand_en = mask_q[NUM_BG];
    for (int i = 0; i < NUM_BG; i++) begin
      if (cnt == 4'(i + 1)) begin
        cand    = bg_q[i];
        cand_en = mask_q[i];
      end
    end
  end

  pe_rank u_rank_top (.cand(cand), .cand_en(cand_en), .incumbent(top_q), .wins(win_top));
  pe_rank u_rank_sec (.cand(cand), .cand_en(cand_en), .incumbent(sec_q), .wins(win_sec));

  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid)             state_nx = ST_SCAN;
      ST_SCAN:  if (cnt == 4'(NUM_BG))    state_nx = ST_REQ0;
      ST_REQ0:  if (pram_gnt)             state_nx = ST_WAIT0;
      ST_WAIT0: if (pram_rvalid)          state_nx = (addr1 == addr0) ? ST_OUT : ST_REQ1;
      ST_REQ1:  if (pram_gnt)             state_nx = ST_WAIT1;
      ST_WAIT1: if (pram_rvalid)          state_nx = ST_OUT;
      ST_OUT:   if (out_ready)            state_nx = ST_IDLE;
      default:                            state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt      <= '0;
      bg_q     <= '0;
      obj_q    <= '0;
      mask_q   <= '0;
      eff_q    <= 1'b0;
      top_q    <= '0;
      sec_q    <= '0;
      color0_q <= '0;
      color1_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          // Source identity comes from the port position, not the entry fields.
          for (int i = 0; i < NUM_BG; i++) begin
            bg_q[i]        <= in_bg[i];
            bg_q[i].is_obj <= 1'b0;
            bg_q[i].bg_no  <= 3'(i);
          end
          obj_q        <= in_obj;
          obj_q.is_obj <= 1'b1;
          obj_q.bg_no  <= 3'd0;
          mask_q       <= in_mask;
          eff_q        <= in_effects;
          top_q        <= '0;
          sec_q        <= '0;
          cnt          <= '0;
        end
        ST_SCAN: begin
          cnt <= cnt + 4'd1;
          if (win_top) begin
            sec_q <= top_q;
            top_q <= cand;
          end else if (win_sec) begin
            sec_q <= cand;
          end
        end
        ST_WAIT0: if (pram_rvalid) begin
          color0_q <= pram_rdata[14:0];
          if (addr1 == addr0) color1_q <= pram_rdata[14:0];
        end
        ST_WAIT1: if (pram_rvalid) color1_q <= pram_rdata[14:0];
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == ST_IDLE) && !clear;
  assign out_valid   = (state == ST_OUT);
  assign pram_req    = (state == ST_REQ0) || (state == ST_REQ1);
  assign pram_addr   = (state == ST_REQ0) ? PRAM_AW'(addr0) :
                       (state == ST_REQ1) ? PRAM_AW'(addr1) : '0;
  assign out_layer0  = top_q;
  assign out_layer1  = sec_q;
  assign out_color0  = color0_q;
  assign out_color1  = color1_q;
  assign out_effects = eff_q;

endmodule
